// File: rtl/axi_write_buffer.sv
// Posted-write buffer between the store path and the AXI write channels.
// Entries stay live until their B response returns; loads can check against them and forward from them.
module axi_write_buffer #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESET,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_strb,
    input  logic [ADDR_W-1:0]     chk_addr,
    output logic                  chk_hit,
    output logic                  chk_fwd_valid,
    output logic [DATA_W-1:0]     chk_fwd_data,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic                  wr_err,
    output logic                  idle
);
    localparam int unsigned SW  = DATA_W / 8;
    localparam int unsigned OFF = $clog2(SW);
    localparam int unsigned IW  = $clog2(DEPTH);
    localparam int unsigned PW  = IW + 1;
    localparam logic [PW-1:0] DepthP  = PW'(DEPTH);
    localparam logic [PW-1:0] MaxOutP = PW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] OneP    = PW'(1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [SW-1:0]     strb_q [DEPTH];

    logic [PW-1:0] tail_q, tail_d, aw_q, aw_d, w_q, w_d, head_q, head_d;
    logic [PW-1:0] count, aw_inflight;
    logic          wr_err_q, wr_err_d;
    logic          accept, aw_fire, w_fire, b_fire;

    logic [IW-1:0]     idx;
    logic [SW-1:0]     young_strb;
    logic [DATA_W-1:0] young_data;
    logic              unused_chk_lsb;

    assign count       = tail_q - head_q;
    assign aw_inflight = aw_q - head_q;

    assign wr_ready = !M_AXI_ARESET && (count != DepthP);
    assign accept   = wr_valid && wr_ready;

    assign M_AXI_AWVALID = (aw_q != tail_q) && (aw_inflight < MaxOutP);
    assign M_AXI_AWADDR  = {addr_q[aw_q[IW-1:0]][ADDR_W-1:OFF], {OFF{1'b0}}};
    assign M_AXI_AWSIZE  = 3'(OFF);
    assign aw_fire       = M_AXI_AWVALID && M_AXI_AWREADY;

    assign M_AXI_WVALID = (w_q != tail_q);
    assign M_AXI_WDATA  = data_q[w_q[IW-1:0]];
    assign M_AXI_WSTRB  = strb_q[w_q[IW-1:0]];
    assign M_AXI_WLAST  = M_AXI_WVALID;
    assign w_fire       = M_AXI_WVALID && M_AXI_WREADY;

    // An entry can only retire once both its address and data beats have left.
    assign M_AXI_BREADY = (head_q != aw_q) && (head_q != w_q);
    assign b_fire       = M_AXI_BVALID && M_AXI_BREADY;

    assign wr_err = wr_err_q;
    assign idle   = (count == '0);

    assign unused_chk_lsb = ^chk_addr[OFF-1:0];

    always_comb begin
        tail_d   = accept  ? tail_q + OneP : tail_q;
        aw_d     = aw_fire ? aw_q + OneP   : aw_q;
        w_d      = w_fire  ? w_q + OneP    : w_q;
        head_d   = b_fire  ? head_q + OneP : head_q;
        wr_err_d = wr_err_q || (b_fire && (M_AXI_BRESP != 2'b00));
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            tail_q   <= '0;
            aw_q     <= '0;
            w_q      <= '0;
            head_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            tail_q   <= tail_d;
            aw_q     <= aw_d;
            w_q      <= w_d;
            head_q   <= head_d;
            wr_err_q <= wr_err_d;
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (accept) begin
            addr_q[tail_q[IW-1:0]] <= wr_addr;
            data_q[tail_q[IW-1:0]] <= wr_data;
            strb_q[tail_q[IW-1:0]] <= wr_strb;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        chk_hit    = 1'b0;
        young_strb = '0;
        young_data = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q[IW-1:0] + IW'(i);
            if ((PW'(i) < count) &&
                (addr_q[idx][ADDR_W-1:OFF] == chk_addr[ADDR_W-1:OFF])) begin
                chk_hit    = 1'b1;
                young_strb = strb_q[idx];
                young_data = data_q[idx];
            end
        end
        chk_fwd_valid = chk_hit && (&young_strb);
        chk_fwd_data  = chk_fwd_valid ? young_data : '0;
    end
endmodule
